// File: rtl/alu_cmd_sequencer.sv
// Command FIFO in front of a combinational 4-bit ALU. It issues one command per cycle
// into a registered result stage with valid/ready, and can chain the last result into operand A.
module alu_cmd_sequencer #(
  parameter int DEPTH = 4,
  parameter int TAGW  = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      in_op,
  input  logic [3:0]      in_a,
  input  logic [3:0]      in_b,
  input  logic            in_chain,
  output logic [1:0]      alu_opcode,
  output logic [3:0]      alu_a,
  output logic [3:0]      alu_b,
  input  logic [3:0]      alu_y,
  input  logic            alu_flag,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [3:0]      out_y,
  output logic            out_flag,
  output logic [1:0]      out_op,
  output logic [TAGW-1:0] out_tag,
  output logic            busy
);
  localparam int AW = $clog2(DEPTH);

  typedef struct packed {
    logic [1:0] op;
    logic [3:0] a;
    logic [3:0] b;
    logic       chain;
  } cmd_t;

  cmd_t            mem_q [DEPTH];
  cmd_t            head;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]     count_q, count_d;
  logic [TAGW-1:0] tag_cnt_q, tag_cnt_d, out_tag_q, out_tag_d;
  logic [3:0]      last_y_q, last_y_d, out_y_q, out_y_d;
  logic [1:0]      out_op_q, out_op_d;
  logic            out_flag_q, out_flag_d, out_valid_q, out_valid_d;
  logic            empty, push, issue;

  assign empty    = (count_q == '0);
  assign in_ready = (count_q < (AW+1)'(DEPTH));
  assign push     = in_valid && in_ready;
  assign issue    = !empty && (!out_valid_q || out_ready);
  assign head     = mem_q[rd_ptr_q];

  // ALU inputs come from the head only; a freshly pushed entry is never bypassed
  assign alu_opcode = empty ? 2'b00 : head.op;
  assign alu_b      = empty ? 4'h0  : head.b;
  assign alu_a      = empty ? 4'h0  : (head.chain ? last_y_q : head.a);

  assign out_valid = out_valid_q;
  assign out_y     = out_y_q;
  assign out_flag  = out_flag_q;
  assign out_op    = out_op_q;
  assign out_tag   = out_tag_q;
  assign busy      = !empty || out_valid_q;

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    tag_cnt_d   = tag_cnt_q;
    last_y_d    = last_y_q;
    out_y_d     = out_y_q;
    out_flag_d  = out_flag_q;
    out_op_d    = out_op_q;
    out_tag_d   = out_tag_q;
    out_valid_d = out_valid_q;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (issue) begin
      rd_ptr_d    = rd_ptr_q + AW'(1);
      out_y_d     = alu_y;
      out_flag_d  = alu_flag;
      out_op_d    = head.op;
      out_tag_d   = tag_cnt_q;
      out_valid_d = 1'b1;
      last_y_d    = alu_y;
      tag_cnt_d   = tag_cnt_q + TAGW'(1);
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
    if (push && !issue)      count_d = count_q + (AW+1)'(1);
    else if (!push && issue) count_d = count_q - (AW+1)'(1);
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= '{op: in_op, a: in_a, b: in_b, chain: in_chain};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      tag_cnt_q   <= '0;
      last_y_q    <= '0;
      out_y_q     <= '0;
      out_flag_q  <= 1'b0;
      out_op_q    <= '0;
      out_tag_q   <= '0;
      out_valid_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      tag_cnt_q   <= tag_cnt_d;
      last_y_q    <= last_y_d;
      out_y_q     <= out_y_d;
      out_flag_q  <= out_flag_d;
      out_op_q    <= out_op_d;
      out_tag_q   <= out_tag_d;
      out_valid_q <= out_valid_d;
    end
  end
endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed bench for alu_cmd_sequencer: a vector table of single commands, plus
// hand sequences for backpressure, tag wrap and mid-stream reset.
module tb_alu_cmd_sequencer;
  logic       clk = 1'b0;
  logic       rst, in_valid, in_ready, in_chain, alu_flag;
  logic       out_valid, out_ready, out_flag, busy;
  logic [1:0] in_op, alu_opcode, out_op;
  logic [3:0] in_a, in_b, alu_a, alu_b, alu_y, out_y, out_tag;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  alu_cmd_sequencer #(.DEPTH(4), .TAGW(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_a(in_a), .in_b(in_b), .in_chain(in_chain),
    .alu_opcode(alu_opcode), .alu_a(alu_a), .alu_b(alu_b),
    .alu_y(alu_y), .alu_flag(alu_flag),
    .out_valid(out_valid), .out_ready(out_ready), .out_y(out_y),
    .out_flag(out_flag), .out_op(out_op), .out_tag(out_tag), .busy(busy)
  );

  // reference model of the external combinational ALU
  always_comb begin
    alu_y    = 4'h0;
    alu_flag = 1'b0;
    case (alu_opcode)
      2'b00: {alu_flag, alu_y} = {1'b0, alu_a} + {1'b0, alu_b};
      2'b01: begin alu_y = alu_a - alu_b; alu_flag = !(alu_a > alu_b); end
      2'b10: begin alu_y = (alu_a > alu_b) ? 4'hF : 4'h0; alu_flag = !(alu_a > alu_b); end
      default: begin alu_y = alu_a & alu_b; alu_flag = ((alu_a & alu_b) == 4'h0); end
    endcase
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [3:0] y, input logic f,
                         input logic [1:0] op, input logic [3:0] t);
    chk({tag, ".out_valid"}, 32'(out_valid), 32'd1);
    chk({tag, ".out_y"},     32'(out_y),     32'(y));
    chk({tag, ".out_flag"},  32'(out_flag),  32'(f));
    chk({tag, ".out_op"},    32'(out_op),    32'(op));
    chk({tag, ".out_tag"},   32'(out_tag),   32'(t));
  endtask

  task automatic drive(input logic v, input logic [1:0] op, input logic [3:0] a,
                       input logic [3:0] b, input logic ch);
    in_valid = v; in_op = op; in_a = a; in_b = b; in_chain = ch;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    drive(1'b0, 2'b00, 4'h0, 4'h0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  typedef struct {
    logic [1:0] op;
    logic [3:0] a, b;
    logic       ch;
    logic [3:0] ea;  // effective operand A seen by the ALU
    logic [3:0] y;
    logic       f;
  } vec_t;

  vec_t vt [12];

  initial begin
    vt[0]  = '{2'b00, 4'h9, 4'h8, 1'b0, 4'h9, 4'h1, 1'b1};
    vt[1]  = '{2'b01, 4'h3, 4'h5, 1'b0, 4'h3, 4'hE, 1'b1};
    vt[2]  = '{2'b11, 4'h0, 4'hC, 1'b1, 4'hE, 4'hC, 1'b0};
    vt[3]  = '{2'b10, 4'h7, 4'h2, 1'b0, 4'h7, 4'hF, 1'b0};
    vt[4]  = '{2'b10, 4'h2, 4'h7, 1'b0, 4'h2, 4'h0, 1'b1};
    vt[5]  = '{2'b11, 4'hC, 4'h3, 1'b0, 4'hC, 4'h0, 1'b1};
    vt[6]  = '{2'b00, 4'h7, 4'h8, 1'b0, 4'h7, 4'hF, 1'b0};
    vt[7]  = '{2'b01, 4'h4, 4'h4, 1'b0, 4'h4, 4'h0, 1'b1};
    vt[8]  = '{2'b01, 4'h9, 4'h4, 1'b0, 4'h9, 4'h5, 1'b0};
    vt[9]  = '{2'b00, 4'h0, 4'h6, 1'b1, 4'h5, 4'hB, 1'b0};
    vt[10] = '{2'b10, 4'h0, 4'hA, 1'b1, 4'hB, 4'hF, 1'b0};
    vt[11] = '{2'b01, 4'h0, 4'hF, 1'b1, 4'hF, 4'h0, 1'b1};

    rst = 1'b1;
    out_ready = 1'b1;
    drive(1'b0, 2'b00, 4'h0, 4'h0, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    chk("rst.in_ready",  32'(in_ready),  32'd1);
    chk("rst.out_valid", 32'(out_valid), 32'd0);
    chk("rst.out_y",     32'(out_y),     32'd0);
    chk("rst.out_flag",  32'(out_flag),  32'd0);
    chk("rst.out_op",    32'(out_op),    32'd0);
    chk("rst.out_tag",   32'(out_tag),   32'd0);
    chk("rst.busy",      32'(busy),      32'd0);
    chk("rst.alu_drive", 32'({alu_opcode, alu_a, alu_b}), 32'd0);

    // table: push one command, check the ALU drive and no bypass, then the result
    for (int i = 0; i < 12; i++) begin
      drive(1'b1, vt[i].op, vt[i].a, vt[i].b, vt[i].ch);
      @(negedge clk);
      drive(1'b0, 2'b00, 4'h0, 4'h0, 1'b0);
      chk($sformatf("vec%0d.no_bypass", i), 32'(out_valid), 32'd0);
      chk($sformatf("vec%0d.busy", i),      32'(busy),      32'd1);
      chk($sformatf("vec%0d.alu_a", i),     32'(alu_a),     32'(vt[i].ea));
      chk($sformatf("vec%0d.alu_b", i),     32'(alu_b),     32'(vt[i].b));
      @(negedge clk);
      chk_out($sformatf("vec%0d", i), vt[i].y, vt[i].f, vt[i].op, 4'(i));
    end
    @(negedge clk);
    chk("vec.drained_valid", 32'(out_valid), 32'd0);
    chk("vec.drained_busy",  32'(busy),      32'd0);

    // backpressure: 5 adds with the consumer stalled; tags continue at 12
    begin
      logic [3:0] ba [5] = '{4'h1, 4'h2, 4'h4, 4'h5, 4'h8};
      logic [3:0] bb [5] = '{4'h1, 4'h3, 4'h4, 4'h6, 4'h8};
      logic [3:0] by [5] = '{4'h2, 4'h5, 4'h8, 4'hB, 4'h0};
      logic       bf [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      out_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
        chk($sformatf("bp.in_ready%0d", i), 32'(in_ready), 32'd1);
        drive(1'b1, 2'b00, ba[i], bb[i], 1'b0);
        @(negedge clk);
      end
      drive(1'b0, 2'b00, 4'h0, 4'h0, 1'b0);
      for (int c = 0; c < 3; c++) begin
        chk($sformatf("bp.full%0d", c), 32'(in_ready), 32'd0);
        chk_out($sformatf("bp.hold%0d", c), by[0], bf[0], 2'b00, 4'd12);
        @(negedge clk);
      end
      out_ready = 1'b1;
      for (int i = 1; i < 5; i++) begin
        @(negedge clk);
        if (i == 1) chk("bp.ready_back", 32'(in_ready), 32'd1);
        chk_out($sformatf("bp.res%0d", i), by[i], bf[i], 2'b00, 4'(12 + i));
      end
      @(negedge clk);
      chk("bp.done_valid", 32'(out_valid), 32'd0);
    end

    // tag wrap after a fresh reset: 17 back-to-back adds
    do_reset();
    for (int c = 0; c <= 17; c++) begin
      if (c < 17) drive(1'b1, 2'b00, 4'(c), 4'h1, 1'b0);
      else        drive(1'b0, 2'b00, 4'h0, 4'h0, 1'b0);
      @(negedge clk);
      if (c == 0) chk("wrap.first_latency", 32'(out_valid), 32'd0);
      else chk_out($sformatf("wrap%0d", c - 1), 4'(c), (c == 16), 2'b00, 4'(c - 1));
    end
    @(negedge clk);

    // mid-stream reset with queued work and a held result
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 2'b00, 4'h3, 4'(i), 1'b0);
      @(negedge clk);
    end
    drive(1'b0, 2'b00, 4'h0, 4'h0, 1'b0);
    chk("mrst.pre_valid", 32'(out_valid), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mrst.out_valid", 32'(out_valid), 32'd0);
    chk("mrst.busy",      32'(busy),      32'd0);
    chk("mrst.in_ready",  32'(in_ready),  32'd1);
    chk("mrst.out_tag",   32'(out_tag),   32'd0);
    out_ready = 1'b1;
    drive(1'b1, 2'b00, 4'hF, 4'h3, 1'b1);
    @(negedge clk);
    drive(1'b0, 2'b00, 4'h0, 4'h0, 1'b0);
    chk("mrst.chain_alu_a", 32'(alu_a), 32'd0);
    @(negedge clk);
    chk_out("mrst.chain", 4'h3, 1'b0, 2'b00, 4'd0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk($sformatf("mrst.no_stale%0d", c), 32'({out_valid, busy}), 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
